pe_mac_gen: RTL and testbench

//  Parametrised integer multiply-accumulate PE for the systolic matrix multiplier; successor to the

---
 rtl/pe_mac_gen.sv | 189 ++++++++++++++++++
 tb/tb_pe_mac_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_mac_gen.sv
// Pipelined integer multiply-accumulate PE for a systolic array: streams k_len operand pairs,
// forwards them east/south and presents one dot product per job. Define PE_SAT_EN to clamp on overflow.
module pe_mac_gen #(
  parameter int DATA_W  = 16,
  parameter int ACC_W   = 48,
  parameter int MUL_LAT = 2,
  parameter int K_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [K_W-1:0]    k_len,
  input  logic              is_signed,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              fwd_valid,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_ovf,
  output logic              busy
);

  if (ACC_W < 2*DATA_W) begin : g_acc_w_chk
    $error("pe_mac_gen: ACC_W must be >= 2*DATA_W");
  end
  if (MUL_LAT < 1) begin : g_mul_lat_chk
    $error("pe_mac_gen: MUL_LAT must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_DONE} state_t;

  localparam int PW = 2*DATA_W + 2;
  localparam logic [MUL_LAT-1:0] LAST_ONLY = MUL_LAT'(1) << (MUL_LAT-1);
  localparam logic [ACC_W-1:0] S_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] S_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t             state_q, state_d;
  logic [K_W-1:0]     cnt_q, cnt_d;
  logic [K_W-1:0]     klen_q, klen_d;
  logic               sgn_q, sgn_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic               rdy_en_q;
  logic [DATA_W-1:0]  a_q, b_q;
  logic               fwd_q;
  logic [DATA_W-1:0]  opa_q, opb_q;
  logic               opv_q;
  logic [ACC_W-1:0]   pd_q [MUL_LAT];
  logic [MUL_LAT-1:0] pv_q;

  logic               accept;
  logic [K_W-1:0]     klen_eff;
  logic [PW-1:0]      mul_a, mul_b, mul_p;
  logic [ACC_W-1:0]   mul_ext;
  logic [ACC_W-1:0]   add_v;
  logic [ACC_W:0]     sum;
  logic               add_ovf;
  logic [ACC_W-1:0]   add_res;

  assign in_ready = rdy_en_q && !clear &&
                    ((state_q == S_IDLE) || ((state_q == S_ACCUM) && (cnt_q < klen_q)));
  assign accept   = in_valid && in_ready;
  assign klen_eff = (k_len == '0) ? K_W'(1) : k_len;

  // Extending both operands to PW bits makes one plain multiply correct for either signedness.
  assign mul_a = {{(PW-DATA_W){sgn_q & opa_q[DATA_W-1]}}, opa_q};
  assign mul_b = {{(PW-DATA_W){sgn_q & opb_q[DATA_W-1]}}, opb_q};
  assign mul_p = mul_a * mul_b;

  if (ACC_W > PW) begin : g_ext
    assign mul_ext = {{(ACC_W-PW){mul_p[PW-1]}}, mul_p};
  end else begin : g_trunc
    assign mul_ext = mul_p[ACC_W-1:0];
  end

  assign add_v   = pd_q[MUL_LAT-1];
  assign sum     = {1'b0, acc_q} + {1'b0, add_v};
  assign add_ovf = sgn_q ? ((acc_q[ACC_W-1] == add_v[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]))
                         : sum[ACC_W];

`ifdef PE_SAT_EN
  assign add_res = !add_ovf ? sum[ACC_W-1:0] :
                   sgn_q    ? (acc_q[ACC_W-1] ? S_MIN : S_MAX) : '1;
`else
  assign add_res = sum[ACC_W-1:0];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    klen_d  = klen_q;
    sgn_d   = sgn_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    if (pv_q[MUL_LAT-1]) begin
      acc_d = add_res;
      ovf_d = ovf_q | add_ovf;
    end
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          klen_d  = klen_eff;
          sgn_d   = is_signed;
          cnt_d   = K_W'(1);
          state_d = (klen_eff == K_W'(1)) ? S_DRAIN : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (accept) begin
          cnt_d = cnt_q + K_W'(1);
          if (cnt_q + K_W'(1) == klen_q) state_d = S_DRAIN;
        end
      end
      // Only the final product is left when it alone occupies the pipeline.
      S_DRAIN: begin
        if (!opv_q && (pv_q == LAST_ONLY)) state_d = S_DONE;
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
          acc_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (clear) begin
      state_d = S_IDLE;
      acc_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      klen_q   <= '0;
      sgn_q    <= 1'b0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      rdy_en_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      fwd_q    <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      opv_q    <= 1'b0;
      pv_q     <= '0;
      for (int unsigned i = 0; i < MUL_LAT; i++) pd_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      klen_q   <= klen_d;
      sgn_q    <= sgn_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      rdy_en_q <= 1'b1;
      fwd_q    <= accept;
      opv_q    <= accept;
      if (accept) begin
        a_q   <= a_in;
        b_q   <= b_in;
        opa_q <= a_in;
        opb_q <= b_in;
      end
      pv_q[0] <= opv_q && !clear;
      pd_q[0] <= mul_ext;
      for (int unsigned i = 1; i < MUL_LAT; i++) begin
        pv_q[i] <= pv_q[i-1] && !clear;
        pd_q[i] <= pd_q[i-1];
      end
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign fwd_valid = fwd_q;
  assign res_valid = (state_q == S_DONE);
  assign res_data  = acc_q;
  assign res_ovf   = ovf_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_pe_mac_gen.sv
// Directed bench for pe_mac_gen: three instances (16/48/lat2, 8/24/lat3, 16/32/lat1) share stimulus.
module tb_pe_mac_gen;

  logic        clk = 1'b0;
  logic        rst, clear, in_valid, is_signed, res_ready;
  logic [7:0]  k_len;
  logic [15:0] a_in, b_in;

  logic        d0_in_ready, d0_fwd, d0_res_valid, d0_ovf, d0_busy;
  logic [15:0] d0_a_out, d0_b_out;
  logic [47:0] d0_res;
  logic        d8_in_ready, d8_fwd, d8_res_valid, d8_ovf, d8_busy;
  logic [7:0]  d8_a_out, d8_b_out;
  logic [23:0] d8_res;
  logic        d32_in_ready, d32_fwd, d32_res_valid, d32_ovf, d32_busy;
  logic [15:0] d32_a_out, d32_b_out;
  logic [31:0] d32_res;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pe_mac_gen #(.DATA_W(16), .ACC_W(48), .MUL_LAT(2), .K_W(8)) d0 (
    .clk(clk), .rst(rst), .clear(clear), .k_len(k_len), .is_signed(is_signed),
    .in_valid(in_valid), .in_ready(d0_in_ready), .a_in(a_in), .b_in(b_in),
    .a_out(d0_a_out), .b_out(d0_b_out), .fwd_valid(d0_fwd), .res_valid(d0_res_valid),
    .res_ready(res_ready), .res_data(d0_res), .res_ovf(d0_ovf), .busy(d0_busy));

  pe_mac_gen #(.DATA_W(8), .ACC_W(24), .MUL_LAT(3), .K_W(8)) d8 (
    .clk(clk), .rst(rst), .clear(clear), .k_len(k_len), .is_signed(is_signed),
    .in_valid(in_valid), .in_ready(d8_in_ready), .a_in(a_in[7:0]), .b_in(b_in[7:0]),
    .a_out(d8_a_out), .b_out(d8_b_out), .fwd_valid(d8_fwd), .res_valid(d8_res_valid),
    .res_ready(res_ready), .res_data(d8_res), .res_ovf(d8_ovf), .busy(d8_busy));

  pe_mac_gen #(.DATA_W(16), .ACC_W(32), .MUL_LAT(1), .K_W(8)) d32 (
    .clk(clk), .rst(rst), .clear(clear), .k_len(k_len), .is_signed(is_signed),
    .in_valid(in_valid), .in_ready(d32_in_ready), .a_in(a_in), .b_in(b_in),
    .a_out(d32_a_out), .b_out(d32_b_out), .fwd_valid(d32_fwd), .res_valid(d32_res_valid),
    .res_ready(res_ready), .res_data(d32_res), .res_ovf(d32_ovf), .busy(d32_busy));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (d0_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b exp 0", d0_in_ready); end
    n_checks++; if (d0_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", d0_busy); end
    tick();
    rst = 1'b0;
    n_checks++; if (d0_in_ready !== 1'b0) begin n_fail++; $display("FAIL rel_in_ready_pre got %b exp 0", d0_in_ready); end
    tick();
    n_checks++; if (d0_in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready got %b exp 1", d0_in_ready); end
    k_len = 8'd4; is_signed = 1'b1;
    send(16'd5, 16'd6);
    send(16'd7, 16'd8);
    n_checks++; if (d0_busy !== 1'b1) begin n_fail++; $display("FAIL midjob_busy got %b exp 1", d0_busy); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (d0_in_ready !== 1'b0) begin n_fail++; $display("FAIL async_in_ready got %b exp 0", d0_in_ready); end
    n_checks++; if (d0_fwd !== 1'b0) begin n_fail++; $display("FAIL async_fwd got %b exp 0", d0_fwd); end
    n_checks++; if ({d0_a_out, d0_b_out} !== 32'h0) begin n_fail++; $display("FAIL async_ab got %h exp 0", {d0_a_out, d0_b_out}); end
    n_checks++; if (d0_busy !== 1'b0) begin n_fail++; $display("FAIL async_busy got %b exp 0", d0_busy); end
    n_checks++; if ({d0_res_valid, d0_ovf, d0_res} !== 50'h0) begin n_fail++; $display("FAIL async_res got %h exp 0", {d0_res_valid, d0_ovf, d0_res}); end
    tick();
    rst = 1'b0;
    n_checks++; if (d0_in_ready !== 1'b0) begin n_fail++; $display("FAIL rel2_in_ready_pre got %b exp 0", d0_in_ready); end
    tick();
    n_checks++; if (d0_in_ready !== 1'b1) begin n_fail++; $display("FAIL rel2_in_ready got %b exp 1", d0_in_ready); end
    n_checks++; if (d0_res_valid !== 1'b0) begin n_fail++; $display("FAIL rel2_no_result got %b exp 0", d0_res_valid); end
  endtask

  task automatic test_signed_dot();
    logic [15:0] av [4] = '{16'd3, -16'sd5, 16'd100, -16'sd1};
    logic [15:0] bv [4] = '{-16'sd2, 16'd7, 16'd100, -16'sd1};
    int n;
    pulse_clear();
    k_len = 8'd4; is_signed = 1'b1; res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(av[i], bv[i]);
      n_checks++; if (d0_fwd !== 1'b1) begin n_fail++; $display("FAIL t2_fwd%0d got %b exp 1", i, d0_fwd); end
      n_checks++; if ({d0_a_out, d0_b_out} !== {av[i], bv[i]}) begin n_fail++; $display("FAIL t2_fwd_ab%0d got %h exp %h", i, {d0_a_out, d0_b_out}, {av[i], bv[i]}); end
    end
    n_checks++; if (d0_in_ready !== 1'b0) begin n_fail++; $display("FAIL t2_drain_in_ready got %b exp 0", d0_in_ready); end
    n = 0;
    while (!d0_res_valid && n < 20) begin tick(); n++; end
    n_checks++; if (n !== 3) begin n_fail++; $display("FAIL t2_latency got %0d exp 3", n); end
    n_checks++; if (d0_fwd !== 1'b0) begin n_fail++; $display("FAIL t2_fwd_end got %b exp 0", d0_fwd); end
    n_checks++; if (d0_res !== 48'd9960) begin n_fail++; $display("FAIL t2_res got %0d exp 9960", d0_res); end
    n_checks++; if (d0_ovf !== 1'b0) begin n_fail++; $display("FAIL t2_ovf got %b exp 0", d0_ovf); end
    tick();
    n_checks++; if ({d0_res_valid, d0_busy} !== 2'b00) begin n_fail++; $display("FAIL t2_after_hs got %b exp 00", {d0_res_valid, d0_busy}); end
  endtask

  task automatic test_unsigned_bubble();
    int n;
    pulse_clear();
    k_len = 8'd2; is_signed = 1'b0; res_ready = 1'b1;
    send(16'd255, 16'd255);
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (d8_in_ready !== 1'b1) begin n_fail++; $display("FAIL t3_bubble_ready%0d got %b exp 1", i, d8_in_ready); end
      tick();
    end
    send(16'd255, 16'd255);
    n = 0;
    while (!d8_res_valid && n < 20) begin tick(); n++; end
    n_checks++; if (n !== 4) begin n_fail++; $display("FAIL t3_latency got %0d exp 4", n); end
    n_checks++; if (d8_res !== 24'd130050) begin n_fail++; $display("FAIL t3_res got %0d exp 130050", d8_res); end
    n_checks++; if (d8_ovf !== 1'b0) begin n_fail++; $display("FAIL t3_ovf got %b exp 0", d8_ovf); end
  endtask

  task automatic test_klen_zero();
    int n;
    pulse_clear();
    k_len = 8'd0; is_signed = 1'b1; res_ready = 1'b1;
    send(-16'sd3, 16'd5);
    n_checks++; if ({d0_busy, d0_in_ready} !== 2'b10) begin n_fail++; $display("FAIL k0_drain got %b exp 10", {d0_busy, d0_in_ready}); end
    n = 0;
    while (!d0_res_valid && n < 20) begin tick(); n++; end
    n_checks++; if (n !== 3) begin n_fail++; $display("FAIL k0_latency got %0d exp 3", n); end
    n_checks++; if (d0_res !== 48'hFFFF_FFFF_FFF1) begin n_fail++; $display("FAIL k0_res got %h exp fffffffffff1", d0_res); end
  endtask

  task automatic test_back_to_back();
    int n;
    pulse_clear();
    k_len = 8'd2; is_signed = 1'b0; res_ready = 1'b0;
    send(16'd2, 16'd3);
    send(16'd4, 16'd5);
    n = 0;
    while (!d0_res_valid && n < 20) begin tick(); n++; end
    n_checks++; if (n !== 3) begin n_fail++; $display("FAIL t4_latency got %0d exp 3", n); end
    k_len = 8'd1; in_valid = 1'b1; a_in = 16'd10; b_in = 16'd10;
    for (int i = 0; i < 10; i++) begin
      n_checks++; if ({d0_res_valid, d0_in_ready} !== 2'b10) begin n_fail++; $display("FAIL t4_hold%0d got %b exp 10", i, {d0_res_valid, d0_in_ready}); end
      n_checks++; if (d0_res !== 48'd26) begin n_fail++; $display("FAIL t4_data%0d got %0d exp 26", i, d0_res); end
      tick();
      n_checks++; if (d0_fwd !== 1'b0) begin n_fail++; $display("FAIL t4_noacc%0d got %b exp 0", i, d0_fwd); end
    end
    res_ready = 1'b1;
    tick();
    n_checks++; if ({d0_res_valid, d0_in_ready} !== 2'b01) begin n_fail++; $display("FAIL t4_hs got %b exp 01", {d0_res_valid, d0_in_ready}); end
    tick();
    in_valid = 1'b0;
    n_checks++; if ({d0_fwd, d0_busy, d0_a_out} !== {2'b11, 16'd10}) begin n_fail++; $display("FAIL t4_next_acc got %h exp 3000a", {d0_fwd, d0_busy, d0_a_out}); end
    n = 0;
    while (!d0_res_valid && n < 20) begin tick(); n++; end
    n_checks++; if ({d0_ovf, d0_res} !== {1'b0, 48'd100}) begin n_fail++; $display("FAIL t4_res2 got %h exp 100", {d0_ovf, d0_res}); end
  endtask

  task automatic test_overflow();
    int n;
`ifdef PE_SAT_EN
    logic [31:0] exp_res = 32'h7FFF_FFFF;
`else
    logic [31:0] exp_res = 32'hBFFD_0003;
`endif
    pulse_clear();
    k_len = 8'd3; is_signed = 1'b1; res_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(16'd32767, 16'd32767);
    n = 0;
    while (!d32_res_valid && n < 20) begin tick(); n++; end
    n_checks++; if (n !== 2) begin n_fail++; $display("FAIL t5_latency got %0d exp 2", n); end
    n_checks++; if (d32_res !== exp_res) begin n_fail++; $display("FAIL t5_res got %h exp %h", d32_res, exp_res); end
    n_checks++; if (d32_ovf !== 1'b1) begin n_fail++; $display("FAIL t5_ovf got %b exp 1", d32_ovf); end
    tick();
    n_checks++; if ({d32_res_valid, d32_ovf, d32_res} !== 34'h0) begin n_fail++; $display("FAIL t5_hs_clr got %h exp 0", {d32_res_valid, d32_ovf, d32_res}); end
  endtask

  task automatic test_clear();
    int n;
    pulse_clear();
    k_len = 8'd5; is_signed = 1'b1; res_ready = 1'b1;
    send(16'd1, 16'd1);
    send(16'd2, 16'd2);
    in_valid = 1'b1; a_in = 16'd3; b_in = 16'd3; clear = 1'b1;
    #1;
    n_checks++; if (d0_in_ready !== 1'b0) begin n_fail++; $display("FAIL t6_clr_ready got %b exp 0", d0_in_ready); end
    tick();
    clear = 1'b0; in_valid = 1'b0;
    n_checks++; if ({d0_busy, d0_fwd, d0_res_valid} !== 3'b000) begin n_fail++; $display("FAIL t6_flushed got %b exp 000", {d0_busy, d0_fwd, d0_res_valid}); end
    n_checks++; if (d0_a_out !== 16'd2) begin n_fail++; $display("FAIL t6_a_hold got %0d exp 2", d0_a_out); end
    k_len = 8'd1; is_signed = 1'b0;
    send(16'd6, 16'd7);
    n = 0;
    while (!d0_res_valid && n < 20) begin tick(); n++; end
    n_checks++; if (n !== 3) begin n_fail++; $display("FAIL t6_latency got %0d exp 3", n); end
    n_checks++; if ({d0_ovf, d0_res} !== {1'b0, 48'd42}) begin n_fail++; $display("FAIL t6_res got %h exp 42", {d0_ovf, d0_res}); end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; is_signed = 1'b0; res_ready = 1'b1;
    k_len = 8'd0; a_in = '0; b_in = '0;
    #1;
    test_reset();
    test_signed_dot();
    test_unsigned_bubble();
    test_klen_zero();
    test_back_to_back();
    test_overflow();
    test_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
